// File: rtl/dram_sim_model_p.sv
// dram_sim_model_p: parametrised behavioural DRAM model for sort-core simulation.
// Serves the core block-transfer interface. It adds a configurable read latency,
// a deterministic ready-stall generator, illegal-request detection and beat counters.
// Ports:
//   CLK, RST         clock; asynchronous active-high reset
//   D_REQ            00 none, 01 read, 10 write, 11 illegal (sampled in IDLE only)
//   D_INITADR        start byte address of the transfer
//   D_ELEM           number of beats to transfer
//   D_DIN            write data, supplied the cycle after D_W
//   D_W              write beat accepted this cycle
//   D_DOUT/D_DOUTEN  read data and its valid, RD_LAT cycles after issue
//   D_BUSY           transfer in progress, including outstanding read data
//   D_ERR            sticky illegal-request flag
//   RD_BEATS         read beats returned since reset
//   WR_BEATS         write beats committed since reset
module dram_sim_model_p #(
  parameter int unsigned DATA_W       = 512,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned ADDR_STEP    = 8,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned STALL_PERIOD = 0,
  parameter int unsigned STALL_LEN    = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        D_REQ,
  input  logic [31:0]       D_INITADR,
  input  logic [31:0]       D_ELEM,
  input  logic [DATA_W-1:0] D_DIN,
  output logic              D_W,
  output logic [DATA_W-1:0] D_DOUT,
  output logic              D_DOUTEN,
  output logic              D_BUSY,
  output logic              D_ERR,
  output logic [31:0]       RD_BEATS,
  output logic [31:0]       WR_BEATS
);

  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] LAST_ADDR = 32'((DEPTH - 1) * ADDR_STEP);
  // One-hot mask of the output stage of the read pipeline.
  localparam logic [RD_LAT-1:0] OUT_BIT = RD_LAT'(1) << (RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [31:0]        addr, addr_d;
  logic [31:0]        remain, remain_d;
  logic               err_d;
  logic               rdy_c;
  logic               issue_c;
  logic               wr_pend;
  logic [IDX_W-1:0]   wr_idx;
  logic [RD_LAT-1:0]  pipe_vld;
  logic [DATA_W-1:0]  pipe_data [RD_LAT];
  logic [DATA_W-1:0]  mem [DEPTH];

  // Byte address to storage index; out-of-range addresses fold modulo DEPTH.
  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a / ADDR_STEP) % DEPTH);
  endfunction

  // Address advance with wrap from the last beat back to zero.
  function automatic logic [31:0] adv_addr(input logic [31:0] a);
    return (a == LAST_ADDR) ? 32'd0 : a + ADDR_STEP;
  endfunction

  // Ready generator: stalls the first STALL_LEN cycles of every STALL_PERIOD.
  if (STALL_PERIOD == 0 || STALL_LEN == 0) begin : g_no_stall
    assign rdy_c = 1'b1;
  end else begin : g_stall
    localparam int unsigned SC_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    logic [SC_W-1:0] stall_cnt;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        stall_cnt <= '0;
      end else if (stall_cnt == SC_W'(STALL_PERIOD - 1)) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + SC_W'(1);
      end
    end

    assign rdy_c = (32'(stall_cnt) >= STALL_LEN);
  end

  assign D_BUSY   = (state != S_IDLE);
  assign D_DOUTEN = pipe_vld[RD_LAT-1];
  assign D_DOUT   = pipe_data[RD_LAT-1];

  // Next-state, transfer bookkeeping and combinational strobes.
  always_comb begin
    state_d  = state;
    addr_d   = addr;
    remain_d = remain;
    err_d    = D_ERR;
    D_W      = 1'b0;
    issue_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (D_REQ == 2'b11 || (D_REQ != 2'b00 && D_ELEM == 32'd0)) begin
          err_d = 1'b1;
        end else if (D_REQ != 2'b00) begin
          addr_d   = D_INITADR;
          remain_d = D_ELEM;
          state_d  = (D_REQ == 2'b01) ? S_READ : S_WRITE;
        end
      end
      S_WRITE: begin
        D_W = rdy_c;
        if (rdy_c) begin
          remain_d = remain - 32'd1;
          addr_d   = adv_addr(addr);
          if (remain == 32'd1) state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (remain != 32'd0 && rdy_c) begin
          issue_c  = 1'b1;
          remain_d = remain - 32'd1;
          addr_d   = adv_addr(addr);
        end
        // All beats issued and only the output stage (if any) still holds data.
        if (remain == 32'd0 && (pipe_vld & ~OUT_BIT) == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, read pipeline, write-commit staging and counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      addr     <= '0;
      remain   <= '0;
      D_ERR    <= 1'b0;
      wr_pend  <= 1'b0;
      wr_idx   <= '0;
      pipe_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_data[i] <= '0;
      RD_BEATS <= '0;
      WR_BEATS <= '0;
    end else begin
      state   <= state_d;
      addr    <= addr_d;
      remain  <= remain_d;
      D_ERR   <= err_d;
      wr_pend <= D_W;
      if (D_W) wr_idx <= word_idx(addr);
      pipe_vld[0]  <= issue_c;
      pipe_data[0] <= issue_c ? mem[word_idx(addr)] : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
      if (wr_pend)            WR_BEATS <= WR_BEATS + 32'd1;
      if (pipe_vld[RD_LAT-1]) RD_BEATS <= RD_BEATS + 32'd1;
    end
  end

  // Storage is never reset; write data lands the cycle after D_W.
  always_ff @(posedge CLK) begin
    if (wr_pend) mem[wr_idx] <= D_DIN;
  end

endmodule

// File: tb/tb_dram_sim_model_p.sv
// tb_dram_sim_model_p: self-checking bench for dram_sim_model_p.
// Two instances: u0 (RD_LAT=1, never stalls) and u1 (RD_LAT=5, stall 1 of every 4).
// A transaction-level model (byte-address memory, issue schedule from the
// stall phase, expected output times) predicts every observed strobe and beat.
module tb_dram_sim_model_p;

  localparam int unsigned DW   = 32;
  localparam int unsigned DEP  = 16;
  localparam int unsigned STEP = 8;
  localparam int unsigned RL0  = 1;
  localparam int unsigned RL1  = 5;
  localparam int unsigned SP1  = 4;
  localparam int unsigned SL1  = 1;

  logic          clk = 1'b0;
  logic          rst    [2];
  logic [1:0]    req    [2];
  logic [31:0]   iadr   [2];
  logic [31:0]   elem   [2];
  logic [DW-1:0] din    [2];
  logic          dw     [2];
  logic [DW-1:0] dout   [2];
  logic          douten [2];
  logic          busy   [2];
  logic          err    [2];
  logic [31:0]   rdb    [2];
  logic [31:0]   wrb    [2];

  dram_sim_model_p #(.DATA_W(DW), .DEPTH(DEP), .ADDR_STEP(STEP), .RD_LAT(RL0),
                     .STALL_PERIOD(0), .STALL_LEN(0)) u0 (
    .CLK(clk), .RST(rst[0]), .D_REQ(req[0]), .D_INITADR(iadr[0]), .D_ELEM(elem[0]),
    .D_DIN(din[0]), .D_W(dw[0]), .D_DOUT(dout[0]), .D_DOUTEN(douten[0]),
    .D_BUSY(busy[0]), .D_ERR(err[0]), .RD_BEATS(rdb[0]), .WR_BEATS(wrb[0]));

  dram_sim_model_p #(.DATA_W(DW), .DEPTH(DEP), .ADDR_STEP(STEP), .RD_LAT(RL1),
                     .STALL_PERIOD(SP1), .STALL_LEN(SL1)) u1 (
    .CLK(clk), .RST(rst[1]), .D_REQ(req[1]), .D_INITADR(iadr[1]), .D_ELEM(elem[1]),
    .D_DIN(din[1]), .D_W(dw[1]), .D_DOUT(dout[1]), .D_DOUTEN(douten[1]),
    .D_BUSY(busy[1]), .D_ERR(err[1]), .RD_BEATS(rdb[1]), .WR_BEATS(wrb[1]));

  always #5 clk = ~clk;

  // Clock edges seen since reset release, per instance; the stall phase is this mod period.
  int unsigned e0 = 0;
  int unsigned e1 = 0;
  always @(posedge clk) e0 <= rst[0] ? 0 : e0 + 1;
  always @(posedge clk) e1 <= rst[1] ? 0 : e1 + 1;

  logic [DW-1:0] mmem [2][DEP];
  int unsigned   exp_rd [2];
  int unsigned   exp_wr [2];
  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;

  function automatic int unsigned rl(input int u);
    return (u == 0) ? RL0 : RL1;
  endfunction

  function automatic bit mdl_rdy(input int u);
    if (u == 0) return 1'b1;
    return (e1 % SP1) >= SL1;
  endfunction

  function automatic int unsigned mdl_idx(input logic [31:0] a);
    return (a / STEP) % DEP;
  endfunction

  function automatic logic [31:0] mdl_next(input logic [31:0] a);
    return (a == 32'((DEP - 1) * STEP)) ? 32'd0 : a + 32'(STEP);
  endfunction

  task automatic do_reset(input int u);
    rst[u] = 1'b1;
    @(negedge clk);
    rst[u] = 1'b0;
    exp_rd[u] = 0;
    exp_wr[u] = 0;
  endtask

  // Write n beats from a0; called and returns at a negedge with the DUT idle.
  task automatic do_write(input int u, input logic [31:0] a0, input int n,
                          input bit rnd, input logic [DW-1:0] base);
    logic [31:0]   a;
    logic [DW-1:0] pdat;
    int unsigned   pidx;
    int            acc, t;
    bit            pend, exp_w;
    req[u] = 2'b10; iadr[u] = a0; elem[u] = 32'(n);
    @(negedge clk);
    req[u] = 2'b00;
    a = a0; acc = 0; t = 0; pend = 1'b0; pidx = 0; pdat = '0;
    while ((acc < n || pend) && t < 200) begin
      if (pend) begin
        din[u] = pdat;
        mmem[u][pidx] = pdat;
        exp_wr[u]++;
        pend = 1'b0;
      end
      exp_w = (acc < n) && mdl_rdy(u);
      n_cmp++;
      if (dw[u] !== exp_w) begin
        n_bad++; $display("FAIL wr_d_w u%0d t%0d: got %b want %b", u, t, dw[u], exp_w);
      end
      n_cmp++;
      if (busy[u] !== (acc < n)) begin
        n_bad++; $display("FAIL wr_busy u%0d t%0d: got %b want %b", u, t, busy[u], acc < n);
      end
      if (exp_w) begin
        pend = 1'b1;
        pidx = mdl_idx(a);
        pdat = rnd ? DW'($urandom) : base + DW'(acc);
        a = mdl_next(a);
        acc++;
      end
      t++;
      @(negedge clk);
    end
    n_cmp++;
    if (t >= 200) begin n_bad++; $display("FAIL wr_timeout u%0d: got %0d beats want %0d", u, acc, n); end
    n_cmp++;
    if (wrb[u] !== exp_wr[u]) begin
      n_bad++; $display("FAIL wr_beats u%0d: got %0d want %0d", u, wrb[u], exp_wr[u]);
    end
    n_cmp++;
    if (busy[u] !== 1'b0) begin n_bad++; $display("FAIL wr_busy_end u%0d: got %b want 0", u, busy[u]); end
  endtask

  // Read n beats from a0; every cycle's D_DOUTEN/D_DOUT/D_BUSY is predicted.
  task automatic do_read(input int u, input logic [31:0] a0, input int n);
    logic [31:0]   a;
    int            out_t [$];
    logic [DW-1:0] out_d [$];
    int            issued, got, t;
    bit            exp_en;
    req[u] = 2'b01; iadr[u] = a0; elem[u] = 32'(n);
    @(negedge clk);
    req[u] = 2'b00;
    a = a0; issued = 0; got = 0; t = 0;
    while (got < n && t < 200) begin
      if (issued < n && mdl_rdy(u)) begin
        out_t.push_back(t + int'(rl(u)));
        out_d.push_back(mmem[u][mdl_idx(a)]);
        a = mdl_next(a);
        issued++;
      end
      exp_en = 1'b0;
      if (out_t.size() > 0) exp_en = (out_t[0] == t);
      n_cmp++;
      if (douten[u] !== exp_en) begin
        n_bad++; $display("FAIL rd_douten u%0d t%0d: got %b want %b", u, t, douten[u], exp_en);
      end
      n_cmp++;
      if (busy[u] !== 1'b1) begin n_bad++; $display("FAIL rd_busy u%0d t%0d: got %b want 1", u, t, busy[u]); end
      if (exp_en) begin
        n_cmp++;
        if (dout[u] !== out_d[0]) begin
          n_bad++; $display("FAIL rd_dout u%0d beat%0d: got %h want %h", u, got, dout[u], out_d[0]);
        end
        void'(out_t.pop_front());
        void'(out_d.pop_front());
        got++;
        exp_rd[u]++;
      end
      t++;
      @(negedge clk);
    end
    n_cmp++;
    if (t >= 200) begin n_bad++; $display("FAIL rd_timeout u%0d: got %0d beats want %0d", u, got, n); end
    n_cmp++;
    if (busy[u] !== 1'b0) begin n_bad++; $display("FAIL rd_busy_end u%0d: got %b want 0", u, busy[u]); end
    n_cmp++;
    if (douten[u] !== 1'b0) begin n_bad++; $display("FAIL rd_douten_end u%0d: got %b want 0", u, douten[u]); end
    n_cmp++;
    if (rdb[u] !== exp_rd[u]) begin
      n_bad++; $display("FAIL rd_beats u%0d: got %0d want %0d", u, rdb[u], exp_rd[u]);
    end
  endtask

  task automatic test_reset;
    for (int u = 0; u < 2; u++) begin
      n_cmp++; if (dw[u]     !== 1'b0)  begin n_bad++; $display("FAIL rst_d_w u%0d: got %b want 0", u, dw[u]); end
      n_cmp++; if (douten[u] !== 1'b0)  begin n_bad++; $display("FAIL rst_douten u%0d: got %b want 0", u, douten[u]); end
      n_cmp++; if (busy[u]   !== 1'b0)  begin n_bad++; $display("FAIL rst_busy u%0d: got %b want 0", u, busy[u]); end
      n_cmp++; if (err[u]    !== 1'b0)  begin n_bad++; $display("FAIL rst_err u%0d: got %b want 0", u, err[u]); end
      n_cmp++; if (dout[u]   !== '0)    begin n_bad++; $display("FAIL rst_dout u%0d: got %h want 0", u, dout[u]); end
      n_cmp++; if (rdb[u]    !== 32'd0) begin n_bad++; $display("FAIL rst_rd_beats u%0d: got %0d want 0", u, rdb[u]); end
      n_cmp++; if (wrb[u]    !== 32'd0) begin n_bad++; $display("FAIL rst_wr_beats u%0d: got %0d want 0", u, wrb[u]); end
    end
  endtask

  task automatic test_basic;
    do_write(0, 32'h0, 4, 1'b0, 32'h10);
    do_read(0, 32'h0, 4);
  endtask

  task automatic test_wrap;
    do_write(0, 32'h78, 3, 1'b0, 32'hA0);
    do_read(0, 32'h78, 3);
    do_read(0, 32'h80, 1);
    n_cmp++;
    if (mmem[0][0] !== 32'hA1) begin n_bad++; $display("FAIL wrap_index0 got %h want a1", mmem[0][0]); end
  endtask

  task automatic test_random;
    logic [31:0] a;
    int          n;
    do_write(0, 32'h0, 16, 1'b1, '0);
    for (int k = 0; k < 10; k++) begin
      a = 32'($urandom_range(0, 15) * STEP) + (($urandom_range(0, 3) == 0) ? 32'h100 : 32'h0);
      n = int'($urandom_range(1, 6));
      if ($urandom_range(0, 1) == 0) do_write(0, a, n, 1'b1, '0);
      else                           do_read(0, a, n);
    end
  endtask

  task automatic test_err;
    do_reset(0);
    n_cmp++; if (err[0] !== 1'b0) begin n_bad++; $display("FAIL err_clear got %b want 0", err[0]); end
    req[0] = 2'b11; iadr[0] = 32'h8; elem[0] = 32'd3;
    @(negedge clk);
    req[0] = 2'b00;
    n_cmp++; if (err[0]  !== 1'b1) begin n_bad++; $display("FAIL err_req11 got %b want 1", err[0]); end
    n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL err_req11_busy got %b want 0", busy[0]); end
    @(negedge clk);
    n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL err_req11_busy2 got %b want 0", busy[0]); end
    do_reset(0);
    n_cmp++; if (err[0] !== 1'b0) begin n_bad++; $display("FAIL err_reset got %b want 0", err[0]); end
    req[0] = 2'b01; iadr[0] = 32'h0; elem[0] = 32'd0;
    @(negedge clk);
    req[0] = 2'b00;
    n_cmp++; if (err[0]  !== 1'b1) begin n_bad++; $display("FAIL err_elem0 got %b want 1", err[0]); end
    n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL err_elem0_busy got %b want 0", busy[0]); end
    do_read(0, 32'h10, 2);
    n_cmp++; if (err[0] !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", err[0]); end
  endtask

  task automatic test_reset_mid;
    req[0] = 2'b01; iadr[0] = 32'h0; elem[0] = 32'd8;
    @(negedge clk);
    req[0] = 2'b00;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (douten[0] !== 1'b1) begin n_bad++; $display("FAIL mid_active got %b want 1", douten[0]); end
    #1 rst[0] = 1'b1;
    #1;
    n_cmp++; if (douten[0] !== 1'b0) begin n_bad++; $display("FAIL mid_douten got %b want 0", douten[0]); end
    n_cmp++; if (busy[0]   !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b want 0", busy[0]); end
    n_cmp++; if (dout[0]   !== '0)   begin n_bad++; $display("FAIL mid_dout got %h want 0", dout[0]); end
    n_cmp++; if (rdb[0]    !== 32'd0) begin n_bad++; $display("FAIL mid_rd_beats got %0d want 0", rdb[0]); end
    n_cmp++; if (wrb[0]    !== 32'd0) begin n_bad++; $display("FAIL mid_wr_beats got %0d want 0", wrb[0]); end
    n_cmp++; if (err[0]    !== 1'b0) begin n_bad++; $display("FAIL mid_err got %b want 0", err[0]); end
    @(negedge clk);
    rst[0] = 1'b0;
    exp_rd[0] = 0;
    exp_wr[0] = 0;
    do_read(0, 32'h0, 8);
  endtask

  task automatic test_stall;
    do_write(1, 32'h0, 16, 1'b1, '0);
    do_read(1, 32'h10, 8);
  endtask

  task automatic test_lat5;
    do_read(1, 32'h70, 2);
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      a = 32'($urandom_range(0, 15) * STEP);
      do_write(1, a, int'($urandom_range(1, 5)), 1'b1, '0);
      do_read(1, a, int'($urandom_range(1, 5)));
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; req[u] = 2'b00; iadr[u] = '0; elem[u] = '0; din[u] = '0;
      exp_rd[u] = 0; exp_wr[u] = 0;
    end
    @(negedge clk);
    test_reset;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    test_basic;
    test_wrap;
    test_random;
    test_err;
    test_reset_mid;
    test_stall;
    test_lat5;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
